// File: rtl/btn_debounce.sv
// Push-button conditioner: input synchroniser, then a qualification FSM that
// commits a level change only after STABLE_CYCLES consecutive equal samples.
module btn_debounce #(
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic btn_i,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  localparam logic [1:0] IDLE_LOW  = 2'd0;
  localparam logic [1:0] WAIT_HIGH = 2'd1;
  localparam logic [1:0] IDLE_HIGH = 2'd2;
  localparam logic [1:0] WAIT_LOW  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   sync_s;

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             btn_reg, btn_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  // Bit 0 captures the raw pin; the FSM only ever looks at the last stage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_i};
    end
  end

  assign sync_s = sync_reg[SYNC_STAGES-1];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    btn_next   = btn_reg;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state_reg)
      IDLE_LOW: begin
        btn_next = 1'b0;
        if (sync_s) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync_s) begin
          state_next = IDLE_LOW;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_HIGH;
          cnt_next   = CNT_ZERO;
          btn_next   = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        btn_next = 1'b1;
        if (!sync_s) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync_s) begin
          state_next = IDLE_HIGH;
          cnt_next   = CNT_ZERO;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE_LOW;
          cnt_next   = CNT_ZERO;
          btn_next   = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        // Corrupted state register: fall back to a quiet released button.
        state_next = IDLE_LOW;
        cnt_next   = CNT_ZERO;
        btn_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg <= IDLE_LOW;
      cnt_reg   <= CNT_ZERO;
      btn_reg   <= 1'b0;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      btn_reg   <= btn_next;
      rise_reg  <= rise_next;
      fall_reg  <= fall_next;
    end
  end

  assign btn_o  = btn_reg;
  assign rise_o = rise_reg;
  assign fall_o = fall_reg;
  assign busy_o = (state_reg == WAIT_HIGH) || (state_reg == WAIT_LOW);

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random segments, checked
// against a run-length model of the debounce rule.
module tb_btn_debounce;

  localparam int SC = 4;
  localparam int SS = 2;

  logic clk_i  = 1'b0;
  logic rstn_i = 1'b0;
  logic btn_i  = 1'b0;
  logic btn_o, rise_o, fall_o, busy_o;

  btn_debounce #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .btn_i  (btn_i),
    .btn_o  (btn_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference: pin samples delayed SS edges, plus the length of the current
  // run of samples that disagree with the committed level.
  bit m_dly[SS];
  bit m_lvl;
  int m_run;
  bit m_rise, m_fall;

  int edge_cnt, rise_cnt, fall_cnt, last_rise_edge, last_fall_edge;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_dly[i] = 1'b0;
    m_lvl  = 1'b0;
    m_run  = 0;
    m_rise = 1'b0;
    m_fall = 1'b0;
  endtask

  task automatic model_edge(input bit pin);
    bit seen;
    seen = m_dly[SS-1];
    for (int i = SS - 1; i > 0; i--) m_dly[i] = m_dly[i-1];
    m_dly[0] = pin;
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (seen == m_lvl) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == SC) begin
        m_lvl  = seen;
        m_run  = 0;
        m_rise = seen;
        m_fall = !seen;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_btn"},  32'(btn_o),  32'(m_lvl));
    chk({tag, "_rise"}, 32'(rise_o), 32'(m_rise));
    chk({tag, "_fall"}, 32'(fall_o), 32'(m_fall));
    chk({tag, "_busy"}, 32'(busy_o), 32'(m_run > 0));
  endtask

  task automatic clear_stats();
    edge_cnt = 0; rise_cnt = 0; fall_cnt = 0;
    last_rise_edge = -1; last_fall_edge = -1;
  endtask

  task automatic step(input bit b, input string tag);
    int idx;
    @(negedge clk_i);
    btn_i = b;
    @(posedge clk_i);
    model_edge(b);
    idx = edge_cnt;
    edge_cnt++;
    #1;
    check_outputs(tag);
    if (rise_o) begin rise_cnt++; last_rise_edge = idx; end
    if (fall_o) begin fall_cnt++; last_fall_edge = idx; end
    $display("edge %0d %s: btn_i=%0b -> btn_o=%0b rise=%0b fall=%0b busy=%0b",
             idx, tag, b, btn_o, rise_o, fall_o, busy_o);
  endtask

  // Called 1 time unit after a rising edge: asserts reset between edges.
  task automatic async_reset(input string tag);
    #2;
    rstn_i = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, "_now"});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      btn_i = ~btn_i;
      @(posedge clk_i);
      #1;
      check_outputs({tag, "_hold"});
    end
    rstn_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clear_stats();

    // Reset held with the pin toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      btn_i = ~btn_i;
      @(posedge clk_i);
      #1;
      check_outputs("reset");
    end
    rstn_i = 1'b1;
    repeat (6) step(1'b0, "settle");

    // Clean press
    clear_stats();
    repeat (12) step(1'b1, "press");
    chk("press_rises", 32'(rise_cnt), 32'd1);
    chk("press_latency", 32'(last_rise_edge), 32'd5);

    // Clean release
    clear_stats();
    repeat (12) step(1'b0, "release");
    chk("release_falls", 32'(fall_cnt), 32'd1);
    chk("release_latency", 32'(last_fall_edge), 32'd5);
    chk("release_rises", 32'(rise_cnt), 32'd0);

    // Bounce rejection
    clear_stats();
    repeat (3) step(1'b1, "bounce");
    repeat (10) step(1'b0, "bounce_lo");
    chk("bounce_rises", 32'(rise_cnt), 32'd0);
    chk("bounce_level", 32'(btn_o), 32'd0);

    // Reset in the middle of a press, released with the pin still high
    clear_stats();
    repeat (4) step(1'b1, "midpress");
    async_reset("midrst");
    clear_stats();
    repeat (10) step(1'b1, "post_rst");
    chk("post_rst_rises", 32'(rise_cnt), 32'd1);
    chk("post_rst_latency", 32'(last_rise_edge), 32'd5);

    // Reset while the rise pulse is high
    repeat (8) step(1'b0, "to_low");
    clear_stats();
    repeat (6) step(1'b1, "to_pulse");
    chk("pulse_before_rst", 32'(rise_o), 32'd1);
    async_reset("pulserst");
    repeat (8) step(1'b0, "after_pulserst");

    // Glitch storm, then settle high
    clear_stats();
    for (int i = 0; i < 20; i++) step(bit'(i % 2 == 0), "storm");
    chk("storm_rises", 32'(rise_cnt), 32'd0);
    chk("storm_level", 32'(btn_o), 32'd0);
    clear_stats();
    repeat (12) step(1'b1, "storm_settle");
    chk("storm_settle_rises", 32'(rise_cnt), 32'd1);
    chk("storm_settle_latency", 32'(last_rise_edge), 32'd5);

    // Random segments with occasional asynchronous reset
    for (int seg = 0; seg < 60; seg++) begin
      bit lvl;
      int len;
      lvl = bit'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int k = 0; k < len; k++) step(lvl, "rand");
      if ($urandom_range(0, 14) == 0) async_reset("rand_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
